// File: rtl/mc14500_pkg.sv
//==============================================================================
// Module      : mc14500_pkg
// Description : Shared types for the MC14500B fetch path: opcode set, fetch
//               controller states and the prefetch FIFO entry layout.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

package mc14500_pkg;

    localparam int OPCODE_WIDTH   = 4;
    localparam int DEF_ADDR_WIDTH = 8;
    localparam int DEF_DATA_WIDTH = 8;

    typedef enum logic [OPCODE_WIDTH-1:0] {
        NOPO = 4'd0, LD, LDC, AND, ANDC, OR, ORC, XNOR,
        STO, STOC, IEN, OEN, JMP, RTN, SKZ, NOPF
    } opcode_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        REQ     = 2'd1,
        DISCARD = 2'd2
    } fetch_state_t;

    // Default-width entry; the fetch unit re-declares it at its own widths.
    typedef struct packed {
        logic [DEF_DATA_WIDTH-1:0] data;
        logic [DEF_ADDR_WIDTH-1:0] pc;
    } fifo_entry_t;

endpackage

`default_nettype wire

// File: rtl/fetch_fifo.sv
//==============================================================================
// Module      : fetch_fifo
// Description : Synchronous prefetch FIFO of fetched entries; flush wins over
//               push and pop.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module fetch_fifo
    import mc14500_pkg::*;
#(
    parameter int  DEPTH   = 2,
    parameter type ENTRY_T = fifo_entry_t,
    parameter int  CNT_W   = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic             flush,
    input  ENTRY_T           wdata,
    output ENTRY_T           rdata,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    ENTRY_T            mem_q [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic [CNT_W-1:0]  count_q;
    logic              do_push;
    logic              do_pop;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_q <= ptr_inc(wr_ptr_q);
            end
            if (do_pop) begin
                rd_ptr_q <= ptr_inc(rd_ptr_q);
            end
            count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !flush) begin
            mem_q[wr_ptr_q] <= wdata;
        end
    end

endmodule

`default_nettype wire

// File: rtl/instruction_fetch.sv
//==============================================================================
// Module      : instruction_fetch
// Description : MC14500B fetch unit: req/ack program-memory reader feeding a
//               prefetch FIFO, with redirect flush. IFETCH_PERF_EN adds
//               saturating fetch/flush counters.
// Revision    : 1.0 - initial release
//==============================================================================
`default_nettype none

module instruction_fetch
    import mc14500_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                           clk,
    input  logic                           reset_n,
    input  logic                           redirect_valid,
    input  logic [ADDR_WIDTH-1:0]          redirect_addr,
    output logic                           mem_req,
    output logic [ADDR_WIDTH-1:0]          mem_addr,
    input  logic                           mem_ack,
    input  logic [DATA_WIDTH-1:0]          mem_rdata,
    output logic                           instr_valid,
    input  logic                           instr_ready,
    output logic [OPCODE_WIDTH-1:0]        instr_opcode,
    output logic [DATA_WIDTH-OPCODE_WIDTH-1:0] instr_operand,
    output logic [ADDR_WIDTH-1:0]          instr_pc,
    output logic [15:0]                    fetch_count,
    output logic [15:0]                    flush_count
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    typedef struct packed {
        logic [DATA_WIDTH-1:0] data;
        logic [ADDR_WIDTH-1:0] pc;
    } entry_t;

    fetch_state_t          state_q, state_d;
    logic [ADDR_WIDTH-1:0] fetch_addr_q, fetch_addr_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
    logic                  push;
    logic                  pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    logic [CNT_W-1:0]      fifo_count;
    logic                  room_after_push;
    entry_t                wr_entry;
    entry_t                head;

    // mem_req is decoded straight from the async-reset state so it drops
    // the moment reset_n falls.
    assign mem_req     = (state_q != IDLE);
    assign mem_addr    = mem_addr_q;
    assign instr_valid = !fifo_empty;
    assign pop         = instr_valid && instr_ready && !redirect_valid;
    assign wr_entry    = '{data: mem_rdata, pc: fetch_addr_q};

    // After this cycle's push (and any pop) there is still a slot for the next read.
    assign room_after_push = (fifo_count < CNT_W'(FIFO_DEPTH - 1)) || pop;

    fetch_fifo #(
        .DEPTH   (FIFO_DEPTH),
        .ENTRY_T (entry_t),
        .CNT_W   (CNT_W)
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .pop     (pop),
        .flush   (redirect_valid),
        .wdata   (wr_entry),
        .rdata   (head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign instr_opcode  = instr_valid ? head.data[DATA_WIDTH-1 -: OPCODE_WIDTH] : '0;
    assign instr_operand = instr_valid ? head.data[DATA_WIDTH-OPCODE_WIDTH-1:0] : '0;
    assign instr_pc      = instr_valid ? head.pc : '0;

    always_comb begin
        state_d      = state_q;
        fetch_addr_d = fetch_addr_q;
        mem_addr_d   = mem_addr_q;
        push         = 1'b0;

        case (state_q)
            IDLE: begin
                if (!fifo_full || pop) begin
                    state_d = REQ;
                end
            end
            REQ: begin
                if (mem_ack) begin
                    push         = 1'b1;
                    fetch_addr_d = fetch_addr_q + ADDR_WIDTH'(1);
                    if (!room_after_push) begin
                        state_d = IDLE;
                    end
                end
            end
            DISCARD: begin
                if (mem_ack) begin
                    state_d = REQ;
                end
            end
            default: state_d = IDLE;
        endcase

        if (redirect_valid) begin
            push         = 1'b0;
            fetch_addr_d = redirect_addr;
            state_d      = (mem_req && !mem_ack) ? DISCARD : REQ;
        end

        // A new request latches its address; DISCARD keeps the old one.
        if (state_d == REQ) begin
            mem_addr_d = fetch_addr_d;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            fetch_addr_q <= '0;
            mem_addr_q   <= '0;
        end else begin
            state_q      <= state_d;
            fetch_addr_q <= fetch_addr_d;
            mem_addr_q   <= mem_addr_d;
        end
    end

`ifdef IFETCH_PERF_EN
    logic [15:0] fetch_count_q;
    logic [15:0] flush_count_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fetch_count_q <= '0;
            flush_count_q <= '0;
        end else begin
            if (push && (fetch_count_q != 16'hFFFF)) begin
                fetch_count_q <= fetch_count_q + 16'd1;
            end
            if (redirect_valid && (flush_count_q != 16'hFFFF)) begin
                flush_count_q <= flush_count_q + 16'd1;
            end
        end
    end

    assign fetch_count = fetch_count_q;
    assign flush_count = flush_count_q;
`else
    assign fetch_count = '0;
    assign flush_count = '0;
`endif

endmodule

`default_nettype wire
